// File: rtl/apb_icn_master_arb.sv
// Round-robin two-requester APB master for the SPI-slave interconnect port.
// Sequences SETUP/ACCESS, handles wait states, pslverr and a stall timeout.
module apb_icn_master_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [1:0]  strb0,
    input  logic [1:0]  strb1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        err,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  psel,
    output logic        penable,
    output logic        pwrite,
    output logic [19:0] paddr,
    output logic [15:0] pwdata,
    output logic [1:0]  pstrb,
    input  logic [15:0] prdata_icn,
    input  logic        pready_icn,
    input  logic        pslverr_icn
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] wait_q, wait_d;

    logic          done0_d, done1_d, err_d, penable_d, pwrite_d;
    logic [15:0]   rdata_d, pwdata_d;
    logic [1:0]    grant_d, psel_d, pstrb_d;
    logic [19:0]   paddr_d;

    logic          elig0, elig1, pick1, sel_wr, timed_out;
    logic [19:0]   sel_addr;
    logic [15:0]   sel_wdata;
    logic [1:0]    sel_strb;

    // A pending done pulse blocks arbitration, forcing one idle cycle between transfers.
    always_comb begin
        elig0     = req0 & ~done0 & ~done1;
        elig1     = req1 & ~done0 & ~done1;
        pick1     = elig1 & (~elig0 | ~last_q);
        sel_wr    = pick1 ? wr1    : wr0;
        sel_addr  = pick1 ? addr1  : addr0;
        sel_wdata = pick1 ? wdata1 : wdata0;
        sel_strb  = pick1 ? strb1  : strb0;
        timed_out = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT));
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wait_d    = wait_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata_d   = rdata;
        err_d     = err;
        grant_d   = grant;
        psel_d    = psel;
        penable_d = penable;
        pwrite_d  = pwrite;
        paddr_d   = paddr;
        pwdata_d  = pwdata;
        pstrb_d   = pstrb;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (elig0 | elig1) begin
                    state_d  = SETUP;
                    last_d   = pick1;
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    psel_d   = sel_addr[19] ? 2'b10 : 2'b01;
                    pwrite_d = sel_wr;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_wr ? sel_wdata : '0;
                    pstrb_d  = sel_wr ? sel_strb : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_icn || timed_out) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    wait_d    = '0;
                    done0_d   = ~grant[1];
                    done1_d   = grant[1];
                    if (pready_icn) begin
                        rdata_d = pwrite ? '0 : prdata_icn;
                        err_d   = pslverr_icn;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wait_q  <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            grant   <= '0;
            psel    <= '0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            done0   <= done0_d;
            done1   <= done1_d;
            rdata   <= rdata_d;
            err     <= err_d;
            grant   <= grant_d;
            psel    <= psel_d;
            penable <= penable_d;
            pwrite  <= pwrite_d;
            paddr   <= paddr_d;
            pwdata  <= pwdata_d;
            pstrb   <= pstrb_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
